// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch state encoding and instruction field positions.
package mips_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned OP_W      = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

   localparam int unsigned OP_MSB     = 31;
   localparam int unsigned OP_LSB     = 26;
   localparam int unsigned TGT_MSB    = 25;
   localparam int unsigned IMM_MSB    = 15;
   localparam int unsigned REGION_MSB = 31;
   localparam int unsigned REGION_LSB = 28;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory handshake, control-unit inputs and held-instruction outputs.
interface fetch_unit_if;
   import mips_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;
   logic            stall;
   logic            branch;
   logic            jump;
   logic            zero;
   logic [XLEN-1:0] instr;
   logic [OP_W-1:0] opcode;
   logic            instr_valid;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] link_addr;

   modport master (
      output imem_req, imem_addr, instr, opcode, instr_valid, pc, link_addr,
      input  imem_ack, imem_rdata, stall, branch, jump, zero
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, instr_valid, pc, link_addr,
      output imem_ack, imem_rdata, stall, branch, jump, zero
   );

endinterface

// File: rtl/fetch_unit_npc_sel.sv
// Next-PC selection: jump target beats taken branch beats sequential.
module npc_sel
   import mips_pkg::*;
(
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [XLEN-1:0] instr,
   input  logic            branch,
   input  logic            jump,
   input  logic            zero,
   output logic [XLEN-1:0] next_pc
);

   logic [XLEN-1:0] br_off;
   logic [XLEN-1:0] jmp_tgt;
   logic            unused_op;

   assign br_off    = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
   assign jmp_tgt   = {pc_plus4[REGION_MSB:REGION_LSB], instr[TGT_MSB:0], 2'b00};
   assign unused_op = ^instr[OP_MSB:OP_LSB];

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jmp_tgt;
      end else if (branch && zero) begin
         next_pc = pc_plus4 + br_off;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack and holds the word while it executes.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   localparam logic [XLEN-1:0] PC_INIT = RESET_PC & ~32'd3;

   fetch_state_t    state;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] instr_q;
   logic            req_q;
   logic            valid_q;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] next_pc;

   assign pc_plus4 = pc_q + 32'd4;

   npc_sel u_npc_sel (
      .pc_plus4 (pc_plus4),
      .instr    (instr_q),
      .branch   (bus.branch),
      .jump     (bus.jump),
      .zero     (bus.zero),
      .next_pc  (next_pc)
   );

   // Sequencer: request and output flags are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         pc_q    <= PC_INIT;
         instr_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_FETCH;
               req_q <= 1'b1;
            end
            ST_FETCH: begin
               if (bus.imem_ack) begin
                  instr_q <= bus.imem_rdata;
                  state   <= ST_EXEC;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (!bus.stall) begin
                  pc_q    <= {next_pc[XLEN-1:2], 2'b00};
                  state   <= ST_FETCH;
                  req_q   <= 1'b1;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = {pc_q[XLEN-1:2], 2'b00};
   assign bus.instr       = instr_q;
   assign bus.opcode      = instr_q[OP_MSB:OP_LSB];
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.link_addr   = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the PC corner cases, then random traffic vs a reference model.
module tb_fetch_unit;
   import mips_pkg::*;

   logic clk;
   logic rst;
   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference next-PC from the architectural rules.
   function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                            input logic br, input logic jp, input logic z);
      logic [31:0] seq;
      int          off;
      seq = cur_pc + 32'd4;
      if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      if (br && z) begin
         off = int'($signed(ins[15:0]));
         return seq + 32'(off * 4);
      end
      return seq;
   endfunction

   // Model: fetching while m_req, executing while m_valid, idle when neither.
   logic [31:0] m_pc, m_instr;
   logic        m_req, m_valid;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc    <= 32'h0000_0040;
         m_instr <= 32'h0;
         m_req   <= 1'b0;
         m_valid <= 1'b0;
      end else if (!m_req && !m_valid) begin
         m_req <= 1'b1;
      end else if (m_req) begin
         if (bus.imem_ack) begin
            m_instr <= bus.imem_rdata;
            m_req   <= 1'b0;
            m_valid <= 1'b1;
         end
      end else if (!bus.stall) begin
         m_pc    <= ref_next(m_pc, m_instr, bus.branch, bus.jump, bus.zero);
         m_valid <= 1'b0;
         m_req   <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("imem_req", 32'(bus.imem_req), 32'(m_req));
         chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
         chk("pc", bus.pc, m_pc);
         chk("instr", bus.instr, m_instr);
         chk("opcode", 32'(bus.opcode), m_instr >> 26);
         chk("link_addr", bus.link_addr, m_pc + 32'd4);
         if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
      end
   end

   // Length of the most recent completed run of imem_req cycles.
   int run_cur, last_run;
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         run_cur  <= 0;
         last_run <= 0;
      end else if (bus.imem_req) begin
         run_cur <= run_cur + 1;
      end else begin
         if (run_cur != 0) last_run <= run_cur;
         run_cur <= 0;
      end
   end

   logic [5:0]  e_opcode;
   logic [31:0] e_link, e_pc;
   logic        e_valid;

   task automatic rand_ctrl();
      bus.branch = 1'($urandom);
      bus.jump   = 1'($urandom);
      bus.zero   = 1'($urandom);
      bus.stall  = 1'($urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Serve one instruction: wait for the request, ack after `waits`, then steer EXEC.
   task automatic do_instr(input int waits, input logic [31:0] word, input logic br,
                           input logic jp, input logic z, input int stalls);
      int guard;
      guard = 0;
      while (bus.imem_req !== 1'b1) begin
         if (guard == 8) begin
            chk("req_timeout", 32'(bus.imem_req), 32'd1);
            return;
         end
         bus.imem_ack = 1'($urandom);
         rand_ctrl();
         tick();
         guard++;
      end
      bus.imem_ack = 1'b0;
      repeat (waits) begin
         bus.imem_rdata = $urandom;
         rand_ctrl();
         tick();
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      tick();
      e_opcode       = bus.opcode;
      e_link         = bus.link_addr;
      e_pc           = bus.pc;
      e_valid        = bus.instr_valid;
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      bus.branch     = br;
      bus.jump       = jp;
      bus.zero       = z;
      for (int i = 0; i < stalls; i++) begin
         bus.stall = 1'b1;
         tick();
         bus.imem_ack = 1'($urandom);
      end
      bus.stall = 1'b0;
      tick();
      rand_ctrl();
   endtask

   function automatic logic [31:0] jal_w(input logic [25:0] tgt);
      return {OP_JAL, tgt};
   endfunction

   localparam logic [31:0] ADDI_W = 32'h2008_0005;
   localparam logic [31:0] BEQ_W  = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};

   initial begin
      rst = 1'b1;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.stall = 1'b0;
      bus.branch = 1'b0;
      bus.jump = 1'b0;
      bus.zero = 1'b0;
      repeat (2) tick();
      chk("rst_pc", bus.pc, 32'h40);
      chk("rst_link", bus.link_addr, 32'h44);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_opcode", 32'(bus.opcode), 32'd0);
      rst = 1'b0;

      do_instr(0, ADDI_W, 1'b0, 1'b0, 1'b0, 0);
      chk("addi_opcode", 32'(e_opcode), 32'(OP_ADDI));
      chk("addi_link", e_link, 32'h44);
      chk("addi_valid", 32'(e_valid), 32'd1);
      chk("zero_wait_req_run", 32'(last_run), 32'd1);
      chk("addi_next", bus.imem_addr, 32'h44);

      do_instr(1, jal_w(26'h40), 1'b0, 1'b1, 1'b0, 0);
      chk("jump_0x100", bus.imem_addr, 32'h100);
      do_instr(3, ADDI_W, 1'b0, 1'b0, 1'b0, 0);
      chk("wait3_req_run", 32'(last_run), 32'd4);
      chk("wait3_pc", e_pc, 32'h100);

      do_instr(0, jal_w(26'h80), 1'b0, 1'b1, 1'b0, 0);
      do_instr(0, BEQ_W, 1'b1, 1'b0, 1'b1, 0);
      chk("beq_taken", bus.imem_addr, 32'h1FC);
      do_instr(0, jal_w(26'h80), 1'b0, 1'b1, 1'b0, 0);
      do_instr(2, BEQ_W, 1'b1, 1'b0, 1'b0, 0);
      chk("beq_not_taken", bus.imem_addr, 32'h204);

      do_instr(0, ADDI_W, 1'b0, 1'b0, 1'b0, 5);
      chk("stall_pc", e_pc, 32'h204);
      chk("stall_next", bus.imem_addr, 32'h208);

      // Abandon a pending fetch at 0x80 with reset while memory acks.
      do_instr(0, jal_w(26'h20), 1'b0, 1'b1, 1'b0, 0);
      chk("mid_fetch_addr", bus.imem_addr, 32'h80);
      bus.imem_ack = 1'b0;
      tick();
      rst = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rst_async_req", 32'(bus.imem_req), 32'd0);
      chk("rst_async_pc", bus.pc, 32'h40);
      tick();
      tick();
      chk("rst_ack_instr", bus.instr, 32'd0);
      rst = 1'b0;
      bus.imem_ack = 1'b0;

      do_instr(0, jal_w(26'h0), 1'b0, 1'b1, 1'b0, 0);
      chk("jump_0", bus.imem_addr, 32'h0);
      do_instr(0, BEQ_W, 1'b1, 1'b0, 1'b1, 0);
      chk("neg_wrap", bus.imem_addr, 32'hFFFF_FFFC);
      do_instr(1, ADDI_W, 1'b0, 1'b0, 1'b0, 1);
      chk("seq_wrap", bus.imem_addr, 32'h0);
      do_instr(0, jal_w(26'h3FF_FFFE), 1'b0, 1'b1, 1'b0, 0);
      do_instr(0, ADDI_W, 1'b0, 1'b0, 1'b0, 0);
      do_instr(0, ADDI_W, 1'b0, 1'b0, 1'b0, 0);
      chk("region_cross", bus.imem_addr, 32'h1000_0000);
      do_instr(0, jal_w(26'h4), 1'b0, 1'b1, 1'b0, 0);
      do_instr(0, jal_w(26'h100), 1'b1, 1'b1, 1'b1, 0);
      chk("jal_link", e_link, 32'h1000_0014);
      chk("jal_target", bus.imem_addr, 32'h1000_0400);

      for (int n = 0; n < 300; n++) begin
         do_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
